// File: rtl/gate_input_debouncer.sv
// Per-channel 2-flop synchroniser plus debounce FSM producing clean registered levels.
// Define DEBOUNCE_EDGE_EN to add registered rise_pulse/fall_pulse outputs.
module gate_input_debouncer #(
  parameter int N_CH            = 3,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] clean_out,
  output logic            busy
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
`endif
);

  typedef enum logic {STABLE, PENDING} state_e;

  localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_CH-1:0] pend_d;
  logic            busy_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        state_q <= STABLE;
        cnt_q   <= '0;
        clean_q <= 1'b0;
      end else begin
        s1_q    <= raw_in[g];
        s2_q    <= s1_q;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      case (state_q)
        STABLE: begin
          if (s2_q != clean_q) begin
            // A single-cycle debounce accepts straight away without a PENDING visit.
            if (DEBOUNCE_CYCLES == 1) begin
              clean_d = s2_q;
            end else begin
              state_d = PENDING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (s2_q == clean_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == DB_CNT) begin
            clean_d = s2_q;
            cnt_d   = '0;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    assign pend_d[g]    = (state_d == PENDING);
    assign clean_out[g] = clean_q;

`ifdef DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    // Pulses are registered from the same next-state as clean_q, so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= clean_d & ~clean_q;
        fall_q <= ~clean_d & clean_q;
      end
    end

    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= |pend_d;
  end

  assign busy = busy_q;

endmodule
